// File: rtl/cpu6_dmem.sv
// ---------------------------------------------------------------------------
// cpu6_dmem -- data-memory responder for the cpu6 MEM stage.
//
// Word-organised RAM serving the datapath load/store port. Stores write
// byte/halfword/word lanes through per-lane byte enables. Loads return the
// addressed lane right-justified with zero latency, so the datapath's
// sign/zero extension reads bits [15:0] and [7:0].
//
// Optional feature macro: CPU6_DMEM_ERR_EN
//   defined   : misaligned / out-of-range accesses are detected and
//               suppressed, and the first fault is held in sticky capture
//               registers.
//   undefined : err_* outputs tie to 0 and err_clr is ignored. Lane bits are
//               forced aligned per width, and addresses wrap modulo DEPTH.
//
// Parameters:
//   DEPTH      RAM size in 32-bit words (power of two, >= 4)
//   BASE_ADDR  byte address of word 0 (4*DEPTH aligned)
//
// Ports:
//   clk           rising-edge clock for RAM and capture registers
//   reset         asynchronous active-low reset
//   dataaddr      byte address
//   writedata     right-justified store data
//   memwrite      store request
//   memread       load request (qualifies fault detection only)
//   lswidth       access width (CPU6_LSWIDTH_W / _H / _B)
//   readdata_raw  right-justified load data (combinational)
//   err_valid     sticky: a fault has been captured
//   err_cause     01 misaligned load, 10 misaligned store, 11 out of range
//   err_addr      dataaddr of the captured fault
//   err_pulse     one-cycle pulse the cycle after any fault
//   err_clr       clears err_valid / err_cause / err_addr
// ---------------------------------------------------------------------------

`ifndef CPU6_LSWIDTH_SIZE
`define CPU6_LSWIDTH_SIZE 2
`endif
`ifndef CPU6_LSWIDTH_W
`define CPU6_LSWIDTH_W 2'b00
`endif
`ifndef CPU6_LSWIDTH_H
`define CPU6_LSWIDTH_H 2'b01
`endif
`ifndef CPU6_LSWIDTH_B
`define CPU6_LSWIDTH_B 2'b10
`endif

module cpu6_dmem #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   dataaddr,
    input  logic [31:0]                   writedata,
    input  logic                          memwrite,
    input  logic                          memread,
    input  logic [`CPU6_LSWIDTH_SIZE-1:0] lswidth,
    output logic [31:0]                   readdata_raw,
    output logic                          err_valid,
    output logic [1:0]                    err_cause,
    output logic [31:0]                   err_addr,
    output logic                          err_pulse,
    input  logic                          err_clr
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH) << 2;   // window size in bytes

    logic [31:0]   mem_q [DEPTH];

    // 33-bit subtraction: the top bit is the borrow, i.e. dataaddr < BASE_ADDR.
    logic [32:0]   diff;
    logic [31:0]   offset;
    logic [AW-1:0] idx;
    logic [1:0]    lane_raw;
    logic [1:0]    lane;
    logic          is_b;
    logic          is_h;
    logic          is_w;
    logic          fault;
    logic          load_fault;
    logic          wr_en;
    logic [3:0]    byte_en;
    logic [31:0]   store_data;
    logic [31:0]   word;

    assign diff     = {1'b0, dataaddr} - {1'b0, BASE_ADDR};
    assign offset   = diff[31:0];
    assign idx      = offset[AW+1:2];
    assign lane_raw = offset[1:0];

    // Any encoding other than H or B is handled as a word access.
    assign is_b = (lswidth == `CPU6_LSWIDTH_B);
    assign is_h = (lswidth == `CPU6_LSWIDTH_H);
    assign is_w = !is_b && !is_h;

`ifdef CPU6_DMEM_ERR_EN
    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'b00,
        CAUSE_LOAD_MIS  = 2'b01,
        CAUSE_STORE_MIS = 2'b10,
        CAUSE_RANGE     = 2'b11
    } err_cause_e;

    logic       in_range;
    logic       misaligned;
    err_cause_e cause_now;

    logic        err_valid_q, err_valid_d;
    err_cause_e  err_cause_q, err_cause_d;
    logic [31:0] err_addr_q,  err_addr_d;
    logic        err_pulse_q, err_pulse_d;

    assign in_range   = !diff[32] && (offset < SPAN);
    assign misaligned = (is_w && (lane_raw != 2'b00)) || (is_h && lane_raw[0]);
    assign fault      = (memwrite || memread) && (!in_range || misaligned);
    // A simultaneous read+write is a store, so it reports a store cause.
    assign cause_now  = !in_range ? CAUSE_RANGE :
                        memwrite  ? CAUSE_STORE_MIS : CAUSE_LOAD_MIS;
    assign load_fault = fault && !memwrite;
    assign lane       = lane_raw;

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path
        // leaves it unassigned, which would infer a latch.
        err_valid_d = err_valid_q;
        err_cause_d = err_cause_q;
        err_addr_d  = err_addr_q;
        err_pulse_d = fault;
        // A new fault in the same cycle as err_clr is captured (set wins).
        if (fault && (!err_valid_q || err_clr)) begin
            err_valid_d = 1'b1;
            err_cause_d = cause_now;
            err_addr_d  = dataaddr;
        end else if (err_clr) begin
            err_valid_d = 1'b0;
            err_cause_d = CAUSE_NONE;
            err_addr_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            err_valid_q <= 1'b0;
            err_cause_q <= CAUSE_NONE;
            err_addr_q  <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            err_valid_q <= err_valid_d;
            err_cause_q <= err_cause_d;
            err_addr_q  <= err_addr_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_cause = err_cause_q;
    assign err_addr  = err_addr_q;
    assign err_pulse = err_pulse_q;
`else
    logic unused_inputs;

    assign fault      = 1'b0;
    assign load_fault = 1'b0;
    // Without fault handling, misaligned lanes are snapped down to the width.
    assign lane       = is_w ? 2'b00 :
                        is_h ? {lane_raw[1], 1'b0} : lane_raw;

    assign err_valid  = 1'b0;
    assign err_cause  = 2'b00;
    assign err_addr   = '0;
    assign err_pulse  = 1'b0;

    // Out-of-range addresses wrap: only the index bits of the offset matter.
    assign unused_inputs = ^{err_clr, memread, diff[32], offset[31:AW+2]};
`endif

    // Store lane steering: narrow data is replicated, enables pick the lanes.
    always_comb begin
        byte_en    = 4'b1111;
        store_data = writedata;
        if (is_b) begin
            byte_en    = 4'b0001 << lane;
            store_data = {4{writedata[7:0]}};
        end else if (is_h) begin
            byte_en    = 4'b0011 << lane;
            store_data = {2{writedata[15:0]}};
        end
    end

    assign wr_en = memwrite && !fault;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: RAM contents are deliberately not reset; reset only blocks
            // the write, which also drops a store in flight when reset falls.
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[idx][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

    // Zero-latency load: a same-cycle store is not yet visible (old data).
    assign word = mem_q[idx];

    always_comb begin
        readdata_raw = word >> {lane, 3'b000};
        if (!reset || load_fault) begin
            readdata_raw = '0;
        end
    end

endmodule

// File: tb/tb_cpu6_dmem.sv
// ---------------------------------------------------------------------------
// tb_cpu6_dmem -- self-checking bench for cpu6_dmem.
//
// A byte-array reference model tracks RAM contents; the fault capture model
// follows the first-fault / set-wins rules. Directed vectors come from a
// table, followed by hand sequences, randomized traffic and a reset-mid-store
// sequence. Inputs change on the falling edge like the datapath's EX/MEM
// register; outputs are sampled away from the rising edge.
// ---------------------------------------------------------------------------

`ifndef CPU6_LSWIDTH_SIZE
`define CPU6_LSWIDTH_SIZE 2
`endif
`ifndef CPU6_LSWIDTH_W
`define CPU6_LSWIDTH_W 2'b00
`endif
`ifndef CPU6_LSWIDTH_H
`define CPU6_LSWIDTH_H 2'b01
`endif
`ifndef CPU6_LSWIDTH_B
`define CPU6_LSWIDTH_B 2'b10
`endif

module tb_cpu6_dmem;

    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int unsigned SPAN  = 4 * DEPTH;

    localparam logic [`CPU6_LSWIDTH_SIZE-1:0] LW_ = `CPU6_LSWIDTH_W;
    localparam logic [`CPU6_LSWIDTH_SIZE-1:0] LH_ = `CPU6_LSWIDTH_H;
    localparam logic [`CPU6_LSWIDTH_SIZE-1:0] LB_ = `CPU6_LSWIDTH_B;

    logic                          clk;
    logic                          reset;
    logic [31:0]                   dataaddr;
    logic [31:0]                   writedata;
    logic                          memwrite;
    logic                          memread;
    logic [`CPU6_LSWIDTH_SIZE-1:0] lswidth;
    logic [31:0]                   readdata_raw;
    logic                          err_valid;
    logic [1:0]                    err_cause;
    logic [31:0]                   err_addr;
    logic                          err_pulse;
    logic                          err_clr;

    cpu6_dmem #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .dataaddr     (dataaddr),
        .writedata    (writedata),
        .memwrite     (memwrite),
        .memread      (memread),
        .lswidth      (lswidth),
        .readdata_raw (readdata_raw),
        .err_valid    (err_valid),
        .err_cause    (err_cause),
        .err_addr     (err_addr),
        .err_pulse    (err_pulse),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0]  mb [SPAN];       // byte image of the RAM window
    logic        m_valid;
    logic [1:0]  m_cause;
    logic [31:0] m_addr;
    logic        m_pulse;
    bit          rd_chk_en;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  w;
        logic [31:0] off;
        logic [31:0] wd;
        logic [31:0] exp;
        logic [31:0] mask;   // 0: no explicit readback expectation
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic re, input logic [1:0] w,
                       input logic [31:0] off, input logic [31:0] wd,
                       input logic [31:0] exp, input logic [31:0] mask);
        vec_t v;
        v.we = we; v.re = re; v.w = w; v.off = off; v.wd = wd; v.exp = exp; v.mask = mask;
        vecs.push_back(v);
    endtask

    // Expected behaviour of one access, computed from byte addresses.
    task automatic model_access(input logic we, input logic re, input logic [1:0] w,
                                input logic [31:0] addr,
                                output logic [31:0] exp_rd, output logic flt,
                                output logic [1:0] cause, output int unsigned boff);
        logic [31:0]  off;
        logic         oor;
        int unsigned  wb;
        logic [31:0]  word;
        off  = addr - BASE;
        boff = off % SPAN;
`ifdef CPU6_DMEM_ERR_EN
        oor   = (addr < BASE) || (off >= SPAN);
        flt   = (we || re) && (oor || (w == LW_ && off[1:0] != 2'b00) || (w == LH_ && off[0]));
        cause = oor ? 2'b11 : (we ? 2'b10 : 2'b01);
`else
        oor   = 1'b0;
        flt   = 1'b0;
        cause = 2'b00;
        if (w == LW_)      boff = boff & ~32'd3;
        else if (w == LH_) boff = boff & ~32'd1;
`endif
        wb     = boff - (boff % 4);
        word   = {mb[wb+3], mb[wb+2], mb[wb+1], mb[wb]};
        exp_rd = word >> (8 * (boff % 4));
        if (flt && !we) exp_rd = '0;
    endtask

    task automatic check_err(input string tag);
        check({tag, " err_valid"}, 32'(err_valid), 32'(m_valid));
        check({tag, " err_cause"}, 32'(err_cause), 32'(m_cause));
        check({tag, " err_addr"},  err_addr,       m_addr);
        check({tag, " err_pulse"}, 32'(err_pulse), 32'(m_pulse));
    endtask

    // One MEM-stage cycle: drive on falling edge, check the combinational
    // load, let the rising edge commit, then check model state vs outputs.
    task automatic step(input logic we, input logic re, input logic [1:0] w,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic clr, input string tag, output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        flt;
        logic [1:0]  cause;
        int unsigned boff;
        int          nb;
        @(negedge clk);
        memwrite  = we;
        memread   = re;
        lswidth   = w;
        dataaddr  = addr;
        writedata = wd;
        err_clr   = clr;
        #1;
        model_access(we, re, w, addr, exp_rd, flt, cause, boff);
        rd = readdata_raw;
        if (rd_chk_en && !(flt && we)) check({tag, " rd"}, readdata_raw, exp_rd);
        @(posedge clk);
        #1;
        if (we && !flt) begin
            nb = (w == LW_) ? 4 : ((w == LH_) ? 2 : 1);
            for (int k = 0; k < nb; k++) mb[boff + k] = wd[8*k +: 8];
        end
`ifdef CPU6_DMEM_ERR_EN
        m_pulse = flt;
        if (flt && (!m_valid || clr)) begin
            m_valid = 1'b1;
            m_cause = cause;
            m_addr  = addr;
        end else if (clr) begin
            m_valid = 1'b0;
            m_cause = 2'b00;
            m_addr  = '0;
        end
`endif
        check_err(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        we_r, re_r, clr_r;
        logic [1:0]  w_r;
        logic [31:0] off_r;

        n_cmp = 0; n_bad = 0; rd_chk_en = 0;
        m_valid = 0; m_cause = 0; m_addr = 0; m_pulse = 0;
        reset = 1'b0; memwrite = 0; memread = 0; lswidth = LW_;
        dataaddr = BASE; writedata = 0; err_clr = 0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst rd", readdata_raw, 32'h0);
        check_err("rst");
        @(negedge clk);
        reset = 1'b1;

        // ---- prefill with known nonzero data ----
        for (int i = 0; i < DEPTH; i++)
            step(1, 0, LW_, BASE + 32'(4*i), $urandom | 32'h0100_0001, 0, "fill", rd);
        rd_chk_en = 1;

        // ---- directed table ----
        add(1, 0, LW_, 32'h10, 32'h1111_1111, 32'h0,          32'h0);
        add(1, 0, LW_, 32'h10, 32'hDEAD_BEEF, 32'h1111_1111,  32'hFFFF_FFFF);
        add(0, 1, LW_, 32'h10, 32'h0,         32'hDEAD_BEEF,  32'hFFFF_FFFF);
        add(1, 0, LB_, 32'h13, 32'h0000_00A5, 32'h0,          32'h0);
        add(0, 1, LW_, 32'h10, 32'h0,         32'hA5AD_BEEF,  32'hFFFF_FFFF);
        add(0, 1, LB_, 32'h13, 32'h0,         32'h0000_00A5,  32'h0000_00FF);
        add(1, 0, LH_, 32'h12, 32'h0000_1234, 32'h0,          32'h0);
        add(0, 1, LH_, 32'h12, 32'h0,         32'h0000_1234,  32'h0000_FFFF);
        add(0, 1, LW_, 32'h10, 32'h0,         32'h1234_BEEF,  32'hFFFF_FFFF);
        add(0, 0, LB_, 32'h11, 32'h0,         32'h0012_34BE,  32'hFFFF_FFFF);
`ifndef CPU6_DMEM_ERR_EN
        add(0, 1, LW_, 32'h11, 32'h0,         32'h1234_BEEF,  32'hFFFF_FFFF);
        add(0, 1, LH_, 32'h13, 32'h0,         32'h0000_1234,  32'h0000_FFFF);
        add(0, 1, LW_, 32'h50, 32'h0,         32'h1234_BEEF,  32'hFFFF_FFFF);
        add(0, 1, LW_, 32'hFFFF_FFD0, 32'h0,  32'h1234_BEEF,  32'hFFFF_FFFF);
        add(1, 0, LW_, 32'h54, 32'h0BAD_CAFE, 32'h0,          32'h0);
        add(0, 1, LW_, 32'h14, 32'h0,         32'h0BAD_CAFE,  32'hFFFF_FFFF);
        add(1, 0, LH_, 32'h17, 32'h0000_ABCD, 32'h0,          32'h0);
        add(0, 1, LW_, 32'h14, 32'h0,         32'hABCD_CAFE,  32'hFFFF_FFFF);
`endif
        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].re, vecs[i].w, BASE + vecs[i].off, vecs[i].wd, 0,
                 $sformatf("vec%0d", i), rd);
            if (vecs[i].mask != 0)
                check($sformatf("vec%0d const", i), rd & vecs[i].mask, vecs[i].exp & vecs[i].mask);
        end

`ifdef CPU6_DMEM_ERR_EN
        // ---- fault capture sequences ----
        step(0, 1, LW_, BASE + 32'h11, 32'h0, 0, "misld", rd);
        check("misld rd", rd, 32'h0);
        check("misld pulse", 32'(err_pulse), 32'h1);
        check("misld valid", 32'(err_valid), 32'h1);
        check("misld cause", 32'(err_cause), 32'h1);
        check("misld addr", err_addr, BASE + 32'h11);
        step(1, 0, LW_, BASE + SPAN, 32'h5555_5555, 0, "oorst", rd);
        check("oorst pulse", 32'(err_pulse), 32'h1);
        check("oorst cause", 32'(err_cause), 32'h1);
        check("oorst addr", err_addr, BASE + 32'h11);
        step(0, 1, LW_, BASE, 32'h0, 0, "word0", rd);
        check("word0 pulse", 32'(err_pulse), 32'h0);
        step(1, 0, LH_, BASE + 32'h21, 32'h0000_BEEF, 1, "clrset", rd);
        check("clrset valid", 32'(err_valid), 32'h1);
        check("clrset cause", 32'(err_cause), 32'h2);
        check("clrset addr", err_addr, BASE + 32'h21);
        step(0, 1, LW_, BASE + 32'h20, 32'h0, 0, "word20", rd);
        step(0, 0, LW_, BASE, 32'h0, 1, "clr", rd);
        check("clr valid", 32'(err_valid), 32'h0);
        check("clr cause", 32'(err_cause), 32'h0);
        check("clr addr", err_addr, 32'h0);
        step(0, 1, LB_, BASE - 32'h1, 32'h0, 0, "below", rd);
        check("below rd", rd, 32'h0);
        check("below cause", 32'(err_cause), 32'h3);
        step(0, 0, LW_, BASE, 32'h0, 1, "clr2", rd);
        step(1, 1, LW_, BASE + 32'h22, 32'h7777_7777, 0, "rwmis", rd);
        check("rwmis cause", 32'(err_cause), 32'h2);
`endif

        // ---- randomized traffic ----
        for (int i = 0; i < 300; i++) begin
            we_r  = ($urandom_range(0, 2) == 0);
            re_r  = ($urandom_range(0, 2) == 0);
            clr_r = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 2))
                0:       w_r = LW_;
                1:       w_r = LH_;
                default: w_r = LB_;
            endcase
            if ($urandom_range(0, 7) == 0) off_r = $urandom;
            else                           off_r = 32'($urandom_range(0, SPAN - 1));
            step(we_r, re_r, w_r, BASE + off_r, $urandom, clr_r, $sformatf("rnd%0d", i), rd);
        end

        // ---- reset asserted mid-store ----
        step(1, 0, LW_, BASE + 32'h30, 32'hC0DE_600D, 0, "pre30", rd);
        @(negedge clk);
        memwrite = 1; memread = 0; lswidth = LW_; err_clr = 0;
        dataaddr = BASE + 32'h30; writedata = 32'h0F0F_0F0F;
        #2;
        reset = 1'b0;
        #1;
        m_valid = 0; m_cause = 0; m_addr = 0; m_pulse = 0;
        check("rstmid rd", readdata_raw, 32'h0);
        check_err("rstmid");
        @(posedge clk);
        #1;
        check("rstedge rd", readdata_raw, 32'h0);
        check_err("rstedge");
        @(negedge clk);
        memwrite = 0;
        reset = 1'b1;
        step(0, 1, LW_, BASE + 32'h30, 32'h0, 0, "post30", rd);
        check("post30 const", rd, 32'hC0DE_600D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
